// File: rtl/tracker_display_sequencer.sv
// Rotates the shared 4-digit BCD display through the enabled statistics
// sources, dwelling DWELL_SEC one_Hz_clk ticks on each, with a per-tick snapshot.
module tracker_display_sequencer #(
  parameter int unsigned DWELL_SEC = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        one_Hz_clk,
  input  logic        pause,
  input  logic [3:0]  mode_en,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  output logic [1:0]  mode,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0,
  output logic        blank,
  output logic        mode_change
);

  typedef enum logic {SHOW, BLANK} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_SEC - 1);

  logic        s1_q, s2_q, s3_q;
  logic        live_q, armed_q;
  logic        tick;
  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [15:0] digits_q, digits_d;
  logic        blank_q, blank_d;
  logic        mc_q, mc_d;
  logic        load;
  logic [15:0] sel_val;

  // First enabled index scanning cyclically from base+off; base if none.
  function automatic logic [1:0] first_en(input logic [1:0] base,
                                          input logic [3:0] en,
                                          input logic [1:0] off);
    logic [1:0] r;
    logic [1:0] idx;
    logic       hit;
    r   = base;
    hit = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = base + off + 2'(k);
      if (!hit && en[idx]) begin
        r   = idx;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  // Ticks are only armed once the synchronized input has been seen low after
  // reset, so a level held high through reset does not produce a spurious tick.
  assign tick = s2_q & ~s3_q & armed_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    mc_d     = 1'b0;
    load     = 1'b0;
    if (tick) begin
      case (state_q)
        SHOW: begin
          if (mode_en == '0) begin
            state_d  = BLANK;
            blank_d  = 1'b1;
            digits_d = '1;
            dwell_d  = '0;
          end else begin
            load = 1'b1;
            if (!mode_en[mode_q]) begin
              mode_d  = first_en(mode_q, mode_en, 2'd1);
              dwell_d = '0;
            end else if (!pause) begin
              if (dwell_q == DWELL_LAST) begin
                mode_d  = first_en(mode_q, mode_en, 2'd1);
                dwell_d = '0;
              end else begin
                dwell_d = dwell_q + 4'd1;
              end
            end
          end
        end
        BLANK: begin
          if (mode_en != '0) begin
            state_d = SHOW;
            blank_d = 1'b0;
            mode_d  = first_en(mode_q, mode_en, 2'd0);
            dwell_d = '0;
            load    = 1'b1;
          end
        end
        default: state_d = SHOW;
      endcase
    end

    case (mode_d)
      2'd0:    sel_val = val0;
      2'd1:    sel_val = val1;
      2'd2:    sel_val = val2;
      default: sel_val = val3;
    endcase
    if (load) begin
      digits_d = sel_val;
      mc_d     = (mode_d != mode_q);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      live_q   <= 1'b0;
      armed_q  <= 1'b0;
      state_q  <= SHOW;
      mode_q   <= '0;
      dwell_q  <= '0;
      digits_q <= '0;
      blank_q  <= 1'b0;
      mc_q     <= 1'b0;
    end else begin
      s1_q     <= one_Hz_clk;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      live_q   <= 1'b1;
      if (live_q && !s1_q) armed_q <= 1'b1;
      state_q  <= state_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      mc_q     <= mc_d;
    end
  end

  assign mode        = mode_q;
  assign bcd3        = digits_q[15:12];
  assign bcd2        = digits_q[11:8];
  assign bcd1        = digits_q[7:4];
  assign bcd0        = digits_q[3:0];
  assign blank       = blank_q;
  assign mode_change = mc_q;

endmodule

// File: tb/tb_tracker_display_sequencer.sv
// Directed bench for tracker_display_sequencer with hand-computed expectations.
module tb_tracker_display_sequencer;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        one_Hz_clk = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  mode_en = 4'b1111;
  logic [15:0] val0 = '0, val1 = '0, val2 = '0, val3 = '0;
  logic [1:0]  mode;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic        blank, mode_change;

  int n_tests = 0;
  int n_fail = 0;
  int mc_total = 0;
  int mc_start;

  logic [1:0]  rot_modes [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
  logic [1:0]  skip_modes [7] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3};
  logic [15:0] vals [4] = '{16'h1234, 16'h0056, 16'h0007, 16'h0890};

  tracker_display_sequencer #(.DWELL_SEC(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .one_Hz_clk(one_Hz_clk), .pause(pause),
    .mode_en(mode_en), .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .mode(mode), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .blank(blank), .mode_change(mode_change)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (mode_change === 1'b1) mc_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] digits();
    return {16'h0, bcd3, bcd2, bcd1, bcd0};
  endfunction

  task automatic do_reset();
    @(negedge sys_clk) reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic hz_tick();
    @(negedge sys_clk) one_Hz_clk = 1'b1;
    repeat (6) @(negedge sys_clk);
    one_Hz_clk = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  initial begin
    val0 = vals[0]; val1 = vals[1]; val2 = vals[2]; val3 = vals[3];
    do_reset();
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_digits", digits(), 32'h0);
    check("rst_blank", 32'(blank), 32'd0);
    check("rst_mc", 32'(mode_change), 32'd0);

    // Rotation through all four sources
    mc_start = mc_total;
    for (int i = 0; i < 8; i++) begin
      hz_tick();
      check($sformatf("rot_mode%0d", i), 32'(mode), 32'(rot_modes[i]));
      check($sformatf("rot_dig%0d", i), digits(), {16'h0, vals[rot_modes[i]]});
    end
    check("rot_mc_count", 32'(mc_total - mc_start), 32'd4);

    // Skip disabled sources
    do_reset();
    mode_en = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      hz_tick();
      check($sformatf("skip_mode%0d", i), 32'(mode), 32'(skip_modes[i]));
      check($sformatf("skip_dig%0d", i), digits(), {16'h0, vals[skip_modes[i]]});
    end

    // Pause holds the mode while the snapshot keeps refreshing
    do_reset();
    mode_en = 4'b0010;
    hz_tick();
    check("pause_pre_mode", 32'(mode), 32'd1);
    mode_en = 4'b1111;
    pause = 1'b1;
    mc_start = mc_total;
    for (int i = 0; i < 5; i++) begin
      val1 = 16'h0010 + 16'(i);
      hz_tick();
      check($sformatf("pause_mode%0d", i), 32'(mode), 32'd1);
      check($sformatf("pause_dig%0d", i), digits(), 32'h0010 + 32'(i));
    end
    check("pause_mc_count", 32'(mc_total - mc_start), 32'd0);
    repeat (3) @(negedge sys_clk);
    val1 = 16'h0099;
    repeat (5) @(negedge sys_clk);
    check("freeze_dig", digits(), 32'h0014);
    hz_tick();
    check("freeze_next_dig", digits(), 32'h0099);

    // Blank when nothing enabled, recover to first enabled source
    mode_en = 4'b0000;
    hz_tick();
    check("blank_on", 32'(blank), 32'd1);
    check("blank_dig", digits(), 32'hFFFF);
    check("blank_mode", 32'(mode), 32'd1);
    mode_en = 4'b0100;
    hz_tick();
    check("unblank", 32'(blank), 32'd0);
    check("unblank_mode", 32'(mode), 32'd2);
    check("unblank_dig", digits(), 32'h0007);
    pause = 1'b0;

    // Latency: outputs change on the third sampling edge
    do_reset();
    mode_en = 4'b1111;
    val0 = 16'h4321;
    repeat (3) @(negedge sys_clk);
    one_Hz_clk = 1'b1;
    @(posedge sys_clk); #1;
    check("lat_e0_dig", digits(), 32'h0);
    @(posedge sys_clk); #1;
    check("lat_e1_dig", digits(), 32'h0);
    check("lat_e1_mc", 32'(mode_change), 32'd0);
    @(posedge sys_clk); #1;
    check("lat_e2_dig", digits(), 32'h4321);
    check("lat_e2_mode", 32'(mode), 32'd0);
    @(posedge sys_clk); #1;
    check("lat_e3_mc", 32'(mode_change), 32'd0);
    @(negedge sys_clk) one_Hz_clk = 1'b0;
    repeat (6) @(negedge sys_clk);

    // Reset in the tick cycle wins; held-high input yields no later tick
    mode_en = 4'b0100;
    repeat (2) @(negedge sys_clk);
    mc_start = mc_total;
    one_Hz_clk = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    reset = 1'b1;
    @(posedge sys_clk); #1;
    check("rtick_mode", 32'(mode), 32'd0);
    check("rtick_dig", digits(), 32'h0);
    check("rtick_mc", 32'(mode_change), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge sys_clk);
    check("rtick_after_mode", 32'(mode), 32'd0);
    check("rtick_after_dig", digits(), 32'h0);
    check("rtick_mc_count", 32'(mc_total - mc_start), 32'd0);
    one_Hz_clk = 1'b0;
    repeat (4) @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
